pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register; the next generation of the fixed per-stage registers between IF/ID/EX/MEM/WB.
- Carries a control bundle and a data bundle with valid/ready handshaking, a 2-entry skid buffer, stall and flush inputs, and bubble insertion.
- Outputs have no combinational path from inputs, so any stage boundary in the pipeline can use it.
- When empty or flushed, the control outputs hold a parametrised bubble (NOP) value.

---
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline boundary register with a two-entry skid.
// The main entry M drives the outputs. The skid entry S absorbs one extra
// instruction so that the upstream can see a registered ready signal.
// Every output comes straight from a flop, so the stage can sit at any
// boundary in the pipeline.
module pipe_stage_reg #(
  parameter int                 DATA_W      = 32,
  parameter int                 CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // main (output) entry
  logic              r_m_valid;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  // skid entry
  logic              r_s_valid;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_s_data;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_bubble;

  // Ready depends only on the skid flop. Stall looks like out_ready=0.
  assign w_in_fire  = in_valid & ~r_s_valid;
  assign w_out_fire = r_m_valid & out_ready & ~stall;
  assign w_bubble   = ~r_m_valid & out_ready & ~stall & ~flush;

  // Entry movement: reset takes priority over flush, and flush over normal flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_m_ctrl  <= CTRL_BUBBLE;
      r_m_data  <= '0;
      r_s_valid <= 1'b0;
      r_s_ctrl  <= '0;
      r_s_data  <= '0;
    end else if (flush) begin
      // Drop both entries and any same-cycle input. The data bus keeps its
      // old value because only control has to look like a NOP.
      r_m_valid <= 1'b0;
      r_m_ctrl  <= CTRL_BUBBLE;
      r_s_valid <= 1'b0;
    end else if (w_out_fire) begin
      if (r_s_valid) begin
        // Ready is low while S is valid, so no input can arrive in this cycle.
        r_m_ctrl  <= r_s_ctrl;
        r_m_data  <= r_s_data;
        r_s_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_m_ctrl <= in_ctrl;
        r_m_data <= in_data;
      end else begin
        r_m_valid <= 1'b0;
        r_m_ctrl  <= CTRL_BUBBLE;
      end
    end else if (w_in_fire) begin
      if (!r_m_valid) begin
        r_m_valid <= 1'b1;
        r_m_ctrl  <= in_ctrl;
        r_m_data  <= in_data;
      end else begin
        r_s_valid <= 1'b1;
        r_s_ctrl  <= in_ctrl;
        r_s_data  <= in_data;
      end
    end
  end

  // Saturating count of the idle cycles that the downstream actually consumed.
  always_ff @(posedge clk) begin
    if (reset)
      r_bubble_cnt <= '0;
    else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}}))
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
  end

  assign in_ready   = ~r_s_valid;
  assign out_valid  = r_m_valid;
  assign out_ctrl   = r_m_ctrl;
  assign out_data   = r_m_data;
  assign occupancy  = {1'b0, r_m_valid} + {1'b0, r_s_valid};
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand-written corner
// sequences, then random traffic checked against a queue model.
module tb_pipe_stage_reg;
  localparam int          DW  = 32;
  localparam int          CW  = 16;
  localparam int          NW  = 4;
  localparam logic [15:0] BUB = 16'hA5A5;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] bubble_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of at most two instructions.
  typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] d; } ent_t;
  ent_t        mq[$];
  logic [DW-1:0] m_last = '0;
  int          m_bc   = 0;

  task automatic model_step();
    bit rdy, ofire, ifire, bub;
    rdy   = mq.size() < 2;
    ofire = (mq.size() > 0) && out_ready && !stall;
    ifire = in_valid && rdy;
    bub   = (mq.size() == 0) && out_ready && !stall;
    if (reset) begin
      mq.delete(); m_last = '0; m_bc = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (bub && m_bc < (1 << NW) - 1) m_bc++;
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back('{c: in_ctrl, d: in_data});
      if (mq.size() > 0) m_last = mq[0].d;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: advance the model, take the edge, and sample after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [31:0] d, input bit ordy,
                       input bit st, input bit fl, input bit rs);
    in_valid = iv; in_data = d; in_ctrl = {8'hC0, d[7:0]};
    out_ready = ordy; stall = st; flush = fl; reset = rs;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".out_ctrl"},  out_ctrl, BUB);
    chk({tag, ".out_data"},  out_data, 0);
    chk({tag, ".occupancy"}, occupancy, 0);
    chk({tag, ".in_ready"},  in_ready, 1);
    chk({tag, ".bubble_cnt"}, bubble_cnt, 0);
  endtask

  typedef struct {
    bit iv; logic [31:0] d; bit ordy; bit st; bit fl;
    bit ev; logic [31:0] ed; logic [1:0] eocc; bit erdy; int ebc;
  } vec_t;
  vec_t tbl[14];

  initial begin
    // Columns: in_valid, data, out_ready, stall, flush, then the expected
    // out_valid, out_data, occupancy, in_ready and bubble_cnt after the edge.
    tbl[0]  = '{1, 32'h11, 0, 0, 0,  1, 32'h11, 2'd1, 1, 0};
    tbl[1]  = '{1, 32'h22, 0, 0, 0,  1, 32'h11, 2'd2, 0, 0};
    tbl[2]  = '{1, 32'h99, 0, 0, 0,  1, 32'h11, 2'd2, 0, 0};
    tbl[3]  = '{0, 32'h00, 1, 0, 0,  1, 32'h22, 2'd1, 1, 0};
    tbl[4]  = '{0, 32'h00, 1, 0, 0,  0, 32'h22, 2'd0, 1, 0};
    tbl[5]  = '{1, 32'h33, 0, 0, 0,  1, 32'h33, 2'd1, 1, 0};
    tbl[6]  = '{0, 32'h00, 1, 1, 0,  1, 32'h33, 2'd1, 1, 0};
    tbl[7]  = '{0, 32'h00, 1, 1, 0,  1, 32'h33, 2'd1, 1, 0};
    tbl[8]  = '{0, 32'h00, 1, 1, 0,  1, 32'h33, 2'd1, 1, 0};
    tbl[9]  = '{0, 32'h00, 1, 0, 0,  0, 32'h33, 2'd0, 1, 0};
    tbl[10] = '{1, 32'h55, 0, 0, 0,  1, 32'h55, 2'd1, 1, 0};
    tbl[11] = '{1, 32'h66, 0, 0, 0,  1, 32'h55, 2'd2, 0, 0};
    tbl[12] = '{1, 32'h44, 0, 0, 1,  0, 32'h55, 2'd0, 1, 0};
    tbl[13] = '{0, 32'h00, 1, 0, 0,  0, 32'h55, 2'd0, 1, 1};

    drive(0, 0, 0, 0, 0, 1);
    cycle();
    chk_reset_state("rst0");

    // Skid, stall and flush sequence.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].st, tbl[i].fl, 0);
      cycle();
      chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d.out_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d.out_ctrl", i), out_ctrl,
          tbl[i].ev ? {8'hC0, tbl[i].ed[7:0]} : BUB);
      chk($sformatf("tbl%0d.occupancy", i), occupancy, tbl[i].eocc);
      chk($sformatf("tbl%0d.in_ready", i), in_ready, tbl[i].erdy);
      chk($sformatf("tbl%0d.bubble_cnt", i), bubble_cnt, tbl[i].ebc);
    end

    // Streaming: one instruction per cycle with one cycle of latency.
    drive(0, 0, 0, 0, 0, 1);
    cycle();
    for (int k = 1; k <= 10; k++) begin
      drive(1, k, 1, 0, 0, 0);
      cycle();
      chk($sformatf("stream%0d.data", k), out_data, k);
      chk($sformatf("stream%0d.valid", k), out_valid, 1);
      chk($sformatf("stream%0d.occ", k), occupancy, 1);
      chk($sformatf("stream%0d.rdy", k), in_ready, 1);
    end

    // Bubble saturation with a 4-bit counter.
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, 0, 0, 0);
      cycle();
    end
    chk("bub_sat", bubble_cnt, 15);
    chk("bub_ctrl", out_ctrl, BUB);
    drive(0, 0, 1, 0, 0, 1);
    cycle();
    chk_reset_state("rst_sat");

    // Reset while both entries are full.
    drive(1, 32'hA1, 0, 0, 0, 0); cycle();
    drive(1, 32'hA2, 0, 0, 0, 0); cycle();
    chk("mid.occ", occupancy, 2);
    drive(1, 32'hA3, 0, 0, 0, 1); cycle();
    chk_reset_state("rst_mid");
    drive(1, 32'hB1, 1, 0, 0, 0); cycle();
    chk("mid.after_data", out_data, 32'hB1);
    chk("mid.after_valid", out_valid, 1);

    // Random traffic against the queue model.
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      in_ctrl   = $urandom;
      out_ready = $urandom_range(0, 1);
      stall     = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 59) == 0);
      cycle();
      chk("rnd.out_valid", out_valid, mq.size() > 0);
      chk("rnd.out_ctrl", out_ctrl, (mq.size() > 0) ? mq[0].c : BUB);
      chk("rnd.out_data", out_data, (mq.size() > 0) ? mq[0].d : m_last);
      chk("rnd.occupancy", occupancy, mq.size());
      chk("rnd.in_ready", in_ready, mq.size() < 2);
      chk("rnd.bubble_cnt", bubble_cnt, m_bc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
